tile_judge: RTL

Judges player key presses against the lowest tile line of the falling-tile field and keeps score and lives for the game. It sits downstream of the tile shifter: it watches the bottom line code and the shift pulse, and returns a one-cycle `correct_in` pulse. The shifter uses that pulse to clear its bottom line. The block also owns the game state (idle / play / over) that the shifter and the display use.

---
 rtl/tile_judge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tile_judge.sv
// Hit/miss judge for the falling-tile game: synchronizes lane keys, scores hits
// against the bottom line, tracks lives and owns the idle/play/over game state.
module tile_judge #(
    parameter int LIVES   = 3,
    parameter int SCORE_W = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               shift,
    input  logic [2:0]         bottom,
    input  logic [3:0]         key,
    output logic               correct_in,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    // Lane codes 1..4 select one key; everything else is an empty line.
    function automatic logic [3:0] lane_mask(input logic [2:0] code);
        logic [3:0] m;
        case (code)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0010;
            3'd3:    m = 4'b0100;
            3'd4:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               correct_q, correct_d;
    logic               miss_q, miss_d;
    logic               game_over_q, game_over_d;
    logic [3:0]         key_s1_q, key_s1_d;
    logic [3:0]         key_s2_q, key_s2_d;
    logic [3:0]         key_prev_q, key_prev_d;

    logic [3:0] press_s;
    logic [3:0] lane_s;
    logic       tile_s;
    logic       good_s;
    logic       bad_s;
    logic       drop_s;
    logic       lose_s;

    assign press_s = key_s2_q & ~key_prev_q;
    assign lane_s  = lane_mask(bottom);
    assign tile_s  = |lane_s;
    assign good_s  = tile_s & ~hit_q & (press_s == lane_s);
    assign bad_s   = (|press_s) & ~good_s;
    assign drop_s  = shift & tile_s & ~hit_q & ~good_s;
    // A wrong press and a dropped tile in the same cycle still cost a single life.
    assign lose_s  = bad_s | drop_s;

    // Next-state logic for the key path, game state, score, lives and pulses.
    always_comb begin
        key_s1_d   = key;
        key_s2_d   = key_s1_q;
        key_prev_d = key_s2_q;
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        hit_d      = hit_q;
        correct_d  = 1'b0;
        miss_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = {SCORE_W{1'b0}};
                    lives_d = LIVES_INIT;
                    hit_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PLAY: begin
                // Setting hit wins over the clearing effect of a coincident shift.
                if (good_s) begin
                    correct_d = 1'b1;
                    hit_d     = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_ONE;
                    end else begin
                        score_d = score_q;
                    end
                end else if (shift) begin
                    hit_d = 1'b0;
                end else begin
                    hit_d = hit_q;
                end
                if (lose_s && (lives_q != 3'd0)) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    miss_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            score_q     <= {SCORE_W{1'b0}};
            lives_q     <= LIVES_INIT;
            hit_q       <= 1'b0;
            correct_q   <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
            key_s1_q    <= 4'b0000;
            key_s2_q    <= 4'b0000;
            key_prev_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            hit_q       <= hit_d;
            correct_q   <= correct_d;
            miss_q      <= miss_d;
            game_over_q <= game_over_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_prev_q  <= key_prev_d;
        end
    end

    assign correct_in = correct_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;
    assign game_over  = game_over_q;

endmodule
